// File: rtl/vga_pattern_mux.sv
// rtl/vga_pattern_mux.sv - frame-synchronous VGA pattern selector with override and registered RGB
// Define AUTO_CYCLE_EN to add frame-counted automatic mode cycling.
module vga_pattern_mux #(
  parameter int CW              = 4,
  parameter int NUM_SRC         = 4,
  parameter int SEL_W           = 2,
  parameter int FRAMES_PER_MODE = 120
) (
  input  logic                    clk_25MHz,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    ovr,
  input  logic                    auto_en,
  input  logic                    blank,
  input  logic [10:0]             hcount,
  input  logic [10:0]             vcount,
  input  logic [NUM_SRC*3*CW-1:0] src_color,
  input  logic [3*CW-1:0]         ovr_color,
  output logic [CW-1:0]           vgaRed,
  output logic [CW-1:0]           vgaGreen,
  output logic [CW-1:0]           vgaBlue,
  output logic [SEL_W-1:0]        active_mode,
  output logic                    ovr_active,
  output logic                    mode_changed
);

  logic             ovr_meta;
  logic             ovr_sync;
  logic             fs;
  logic [SEL_W-1:0] next_mode;
  logic [SEL_W-1:0] pix_mode;
  logic             pix_ovr;
  logic [3*CW-1:0]  pix_rgb;

  assign fs = (hcount == 11'd0) && (vcount == 11'd0);

`ifdef AUTO_CYCLE_EN
  localparam int FC_W = $clog2(FRAMES_PER_MODE + 1);
  logic [FC_W-1:0] frame_cnt;
  logic [FC_W-1:0] frame_cnt_next;
  logic [FC_W-1:0] frame_cnt_inc;

  assign frame_cnt_inc = frame_cnt + 1'b1;

  always_comb begin
    next_mode      = (int'(sel) < NUM_SRC) ? sel : '0;
    frame_cnt_next = '0;
    if (auto_en) begin
      next_mode = active_mode;
      if (!ovr_active) begin
        frame_cnt_next = frame_cnt;
        if (fs) begin
          if (frame_cnt_inc == FC_W'(FRAMES_PER_MODE)) begin
            frame_cnt_next = '0;
            next_mode      = (int'(active_mode) == NUM_SRC - 1) ? '0 : active_mode + 1'b1;
          end else begin
            frame_cnt_next = frame_cnt_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else       frame_cnt <= frame_cnt_next;
  end
`else
  wire unused_auto_en = auto_en;

  always_comb begin
    next_mode = (int'(sel) < NUM_SRC) ? sel : '0;
  end
`endif

  // The pixel sampled on the frame-start edge already uses the mode being committed there.
  always_comb begin
    pix_mode = fs ? next_mode : active_mode;
    pix_ovr  = fs ? ovr_sync : ovr_active;
    if (blank)        pix_rgb = '0;
    else if (pix_ovr) pix_rgb = ovr_color;
    else              pix_rgb = src_color[int'(pix_mode)*3*CW +: 3*CW];
  end

  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      ovr_meta     <= 1'b0;
      ovr_sync     <= 1'b0;
      active_mode  <= '0;
      ovr_active   <= 1'b0;
      mode_changed <= 1'b0;
      vgaRed       <= '0;
      vgaGreen     <= '0;
      vgaBlue      <= '0;
    end else begin
      ovr_meta <= ovr;
      ovr_sync <= ovr_meta;
      if (fs) begin
        active_mode <= next_mode;
        ovr_active  <= ovr_sync;
      end
      mode_changed <= fs && ((next_mode != active_mode) || (ovr_sync != ovr_active));
      {vgaRed, vgaGreen, vgaBlue} <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_vga_pattern_mux.sv
// tb/tb_vga_pattern_mux.sv - scoreboard bench for vga_pattern_mux
module tb_vga_pattern_mux;

  typedef struct packed {
    logic [11:0] rgb;
    logic [1:0]  mode;
    logic        ovr;
    logic        chg;
  } obs_t;

  typedef struct packed {
    logic        blank;
    logic [10:0] h;
    logic [10:0] v;
    logic [1:0]  sel;
    logic        ovr;
  } stim_t;

  localparam logic [11:0] S0 = 12'h111;
  localparam logic [11:0] S1 = 12'h222;
  localparam logic [11:0] S2 = 12'h333;
  localparam logic [11:0] S3 = 12'h444;
  localparam logic [11:0] OC = 12'hABC;

  logic        clk_25MHz = 1'b0;
  logic        reset     = 1'b1;
  logic        ovr       = 1'b0;
  logic        auto_en   = 1'b0;
  logic        blank     = 1'b0;
  logic [1:0]  sel       = 2'd0;
  logic [10:0] hcount    = 11'd5;
  logic [10:0] vcount    = 11'd5;
  logic [47:0] src_color = {S3, S2, S1, S0};
  logic [11:0] ovr_color = OC;

  logic [3:0] r, g, b, r3, g3, b3;
  logic [1:0] mode, mode3;
  logic       ovr_act, ovr_act3, chg, chg3;
  obs_t       act, act3;
  obs_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  assign act  = {r, g, b, mode, ovr_act, chg};
  assign act3 = {r3, g3, b3, mode3, ovr_act3, chg3};

  always #20 clk_25MHz = ~clk_25MHz;

  vga_pattern_mux #(.CW(4), .NUM_SRC(4), .SEL_W(2), .FRAMES_PER_MODE(2)) dut (
    .clk_25MHz(clk_25MHz), .reset(reset), .sel(sel), .ovr(ovr), .auto_en(auto_en),
    .blank(blank), .hcount(hcount), .vcount(vcount), .src_color(src_color),
    .ovr_color(ovr_color), .vgaRed(r), .vgaGreen(g), .vgaBlue(b),
    .active_mode(mode), .ovr_active(ovr_act), .mode_changed(chg)
  );

  vga_pattern_mux #(.CW(4), .NUM_SRC(3), .SEL_W(2), .FRAMES_PER_MODE(2)) dut3 (
    .clk_25MHz(clk_25MHz), .reset(reset), .sel(sel), .ovr(ovr), .auto_en(auto_en),
    .blank(blank), .hcount(hcount), .vcount(vcount), .src_color(src_color[35:0]),
    .ovr_color(ovr_color), .vgaRed(r3), .vgaGreen(g3), .vgaBlue(b3),
    .active_mode(mode3), .ovr_active(ovr_act3), .mode_changed(chg3)
  );

  function automatic stim_t mk(input int bl, input int h, input int v, input int s, input int o);
    return {1'(bl), 11'(h), 11'(v), 2'(s), 1'(o)};
  endfunction

  function automatic obs_t ob(input logic [11:0] rgb, input int m, input int o, input int c);
    return {rgb, 2'(m), 1'(o), 1'(c)};
  endfunction

  function automatic logic [11:0] src_of(input int m);
    return 12'(12'h111 * (m + 1));
  endfunction

  task automatic apply(input stim_t s);
    blank = s.blank; hcount = s.h; vcount = s.v; sel = s.sel; ovr = s.ovr;
  endtask

  task automatic cyc();
    @(posedge clk_25MHz);
    @(negedge clk_25MHz);
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b1;
    apply(mk(0, 5, 5, 2, 0));
    q.push_back(ob(12'h000, 0, 0, 0));
    cyc(); cyc();
    e = q.pop_front();
    n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL reset: got %h exp %h", act, e); end
    n_cmp++;
    if (act3 !== e) begin n_err++; $display("FAIL reset_dut3: got %h exp %h", act3, e); end
    reset = 1'b0;
  endtask

  task automatic test_post_reset();
    stim_t st[3]; obs_t ex[3]; obs_t e;
    st = '{mk(0, 10, 3, 2, 0), mk(0, 11, 3, 2, 0), mk(1, 12, 3, 2, 0)};
    ex = '{ob(S0, 0, 0, 0), ob(S0, 0, 0, 0), ob(12'h000, 0, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL post_reset[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_sel_commit();
    stim_t st[3]; obs_t ex[3]; obs_t e;
    st = '{mk(0, 0, 0, 2, 0), mk(0, 1, 0, 2, 0), mk(0, 2, 0, 2, 0)};
    ex = '{ob(S2, 2, 0, 1), ob(S2, 2, 0, 0), ob(S2, 2, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL sel_commit[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_mid_frame_sel();
    stim_t st[5]; obs_t ex[5]; obs_t e;
    st = '{mk(0, 300, 200, 1, 0), mk(0, 301, 200, 1, 0), mk(0, 799, 524, 1, 0),
           mk(0, 0, 0, 1, 0), mk(0, 1, 0, 1, 0)};
    ex = '{ob(S2, 2, 0, 0), ob(S2, 2, 0, 0), ob(S2, 2, 0, 0),
           ob(S1, 1, 0, 1), ob(S1, 1, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL mid_frame_sel[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_blank();
    stim_t st[2]; obs_t ex[2]; obs_t e;
    src_color = '1;
    st = '{mk(1, 5, 5, 1, 0), mk(0, 6, 5, 1, 0)};
    ex = '{ob(12'h000, 1, 0, 0), ob(12'hFFF, 1, 0, 0)};
    for (int i = 0; i < 2; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL blank[%0d]: got %h exp %h", i, act, e); end
    end
    src_color = {S3, S2, S1, S0};
  endtask

  task automatic test_override();
    stim_t st[8]; obs_t ex[8]; obs_t e;
    st = '{mk(0, 797, 524, 1, 1), mk(0, 798, 524, 1, 1), mk(0, 0, 0, 1, 1), mk(0, 1, 0, 1, 0),
           mk(1, 700, 100, 1, 0), mk(0, 300, 300, 1, 0), mk(0, 0, 0, 1, 0), mk(0, 1, 0, 1, 0)};
    ex = '{ob(S1, 1, 0, 0), ob(S1, 1, 0, 0), ob(OC, 1, 1, 1), ob(OC, 1, 1, 0),
           ob(12'h000, 1, 1, 0), ob(OC, 1, 1, 0), ob(S1, 1, 0, 1), ob(S1, 1, 0, 0)};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL override[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_sync_depth();
    stim_t st[5]; obs_t ex[5]; obs_t e;
    st = '{mk(0, 5, 5, 1, 0), mk(0, 6, 5, 1, 1), mk(0, 0, 0, 1, 0), mk(0, 1, 0, 1, 0), mk(0, 0, 0, 1, 0)};
    ex = '{ob(S1, 1, 0, 0), ob(S1, 1, 0, 0), ob(S1, 1, 0, 0), ob(S1, 1, 0, 0), ob(S1, 1, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL sync_depth[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[5]; obs_t ex[5]; obs_t e;
    st = '{mk(0, 0, 0, 3, 0), mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), mk(0, 0, 1, 2, 0), mk(0, 1, 0, 2, 0)};
    ex = '{ob(S3, 3, 0, 1), ob(S0, 0, 0, 1), ob(S0, 0, 0, 0), ob(S0, 0, 0, 0), ob(S0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL back_to_back[%0d]: got %h exp %h", i, act, e); end
    end
  endtask

  task automatic test_illegal_sel();
    stim_t st[4]; obs_t ex[4]; obs_t e;
    st = '{mk(0, 0, 0, 2, 0), mk(0, 4, 4, 3, 0), mk(0, 0, 0, 3, 0), mk(0, 4, 4, 3, 0)};
    ex = '{ob(S2, 2, 0, 1), ob(S2, 2, 0, 0), ob(S0, 0, 0, 1), ob(S0, 0, 0, 0)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]); q.push_back(ex[i]); cyc(); e = q.pop_front(); n_cmp++;
      if (act3 !== e) begin n_err++; $display("FAIL illegal_sel[%0d]: got %h exp %h", i, act3, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t e;
    apply(mk(0, 50, 50, 3, 0)); q.push_back(ob(S3, 3, 0, 0)); cyc(); e = q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL pre_reset: got %h exp %h", act, e); end
    #5 reset = 1'b1;
    q.push_back(ob(12'h000, 0, 0, 0));
    #1 e = q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL async_reset: got %h exp %h", act, e); end
    cyc();
    reset = 1'b0;
    apply(mk(0, 9, 9, 3, 0)); q.push_back(ob(S0, 0, 0, 0)); cyc(); e = q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL after_mid_reset: got %h exp %h", act, e); end
  endtask

`ifdef AUTO_CYCLE_EN
  task automatic test_auto_cycle();
    int   seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int   tail[3] = '{0, 0, 1};
    obs_t e;
    auto_en = 1'b1;
    apply(mk(0, 5, 5, 2, 0)); q.push_back(ob(S0, 0, 0, 0)); cyc(); e = q.pop_front(); n_cmp++;
    if (act !== e) begin n_err++; $display("FAIL auto_frame0: got %h exp %h", act, e); end
    for (int f = 1; f < 9; f++) begin
      apply(mk(0, 0, 0, 2, 0));
      q.push_back(ob(src_of(seq[f]), seq[f], 0, (seq[f] != seq[f-1]) ? 1 : 0));
      cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL auto_frame%0d: got %h exp %h", f, act, e); end
    end
    for (int f = 0; f < 3; f++) begin
      if (f == 1) begin reset = 1'b1; cyc(); reset = 1'b0; end
      apply(mk(0, 0, 0, 2, 0));
      q.push_back(ob(src_of(tail[f]), tail[f], 0, (f == 2) ? 1 : 0));
      cyc(); e = q.pop_front(); n_cmp++;
      if (act !== e) begin n_err++; $display("FAIL auto_reset%0d: got %h exp %h", f, act, e); end
    end
    auto_en = 1'b0;
  endtask
`endif

  initial begin
    @(negedge clk_25MHz);
    test_reset();
    test_post_reset();
    test_sel_commit();
    test_mid_frame_sel();
    test_blank();
    test_override();
    test_sync_depth();
    test_back_to_back();
    test_illegal_sel();
    test_reset_mid_frame();
`ifdef AUTO_CYCLE_EN
    test_auto_cycle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
